// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int unsigned bit_period(input int sim,
                                               input int unsigned sys_clk_freq,
                                               input int unsigned baud_rate,
                                               input int unsigned sim_clks);
        return (sim != 0) ? sim_clks : sys_clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write-side port and line status of the UART transmitter.
interface uart_tx_if #(
    parameter int FIFO_DEPTH_LOG2 = 4
) ();
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     full;
    logic [FIFO_DEPTH_LOG2:0] count;
    logic                     busy;
    logic                     tx;

    modport master (output wr_en, wr_data, input full, count, busy, tx);
    modport slave  (input wr_en, wr_data, output full, count, busy, tx);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is readable without a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on occupancy before any same-cycle pop.
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes shifted out LSB first on a flopped tx pin.
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); next byte may follow with no gap
module uart_tx
    import uart_pkg::*;
#(
    parameter int          SIM              = 0,
    parameter int unsigned SYS_CLK_FREQ     = 100000000,
    parameter int unsigned BAUD_RATE        = 115200,
    parameter int unsigned SIM_CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH_LOG2  = 4
) (
    input logic       clk,
    input logic       rst_n,
    uart_tx_if.slave  bus
);
    localparam int unsigned P  = bit_period(SIM, SYS_CLK_FREQ, BAUD_RATE, SIM_CLKS_PER_BIT);
    localparam int          CW = $clog2(P);

    uart_state_t              state_q, state_d;
    logic [CW-1:0]            baud_q, baud_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     last;
    logic                     pop;
    logic                     empty;
    logic                     full;
    logic [7:0]               rd_data;
    logic [FIFO_DEPTH_LOG2:0] count;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (bus.wr_en),
        .wr_data (bus.wr_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign last      = (baud_q == CW'(P - 1));
    assign bus.tx    = tx_q;
    assign bus.full  = full;
    assign bus.count = count;
    assign bus.busy  = (state_q != IDLE) || (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The pin level is decided from the next state so tx comes straight off a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end
endmodule
